// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register-file access controller.
//   - default data/index widths and WAIT timeout
//   - controller state encoding
//   - REG_ZERO: index of the hardwired-zero register (never written, never forwarded)
package regfile_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int TIMEOUT_DEF = 15;
    localparam int REG_ZERO    = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/operand_forward.sv
// operand_forward: write-to-read forwarding for one source operand.
// In a merged access the register file returns the pre-write value, so a
// pending write to the same (non-zero) register overrides the read data.
// Ports:
//   wr_pend_i  - a write is part of the current access
//   wr_reg_i   - destination index of that write
//   wr_data_i  - data being written
//   src_reg_i  - source index of this operand
//   rf_data_i  - value returned by the register file
//   operand_o  - forwarded operand
module operand_forward
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              wr_pend_i,
    input  logic [ADDR_W-1:0] wr_reg_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] src_reg_i,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [DATA_W-1:0] operand_o
);

    logic hit;

    assign hit       = wr_pend_i && (wr_reg_i != ADDR_W'(REG_ZERO)) && (wr_reg_i == src_reg_i);
    assign operand_o = hit ? wr_data_i : rf_data_i;

endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: merges decode operand reads and writeback writes into
// single register-file accesses (IDLE -> ISSUE -> WAIT -> [HOLD] -> IDLE).
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   dec_valid/dec_ready/dec_rs/dec_rt - operand-read request
//   wb_valid/wb_ready/wb_reg/wb_data  - writeback request
//   op_valid/op_ready/op_a/op_b   - operands to execute
//   rf_en, rf_reg_write, rf_read_reg1/2, rf_write_reg, rf_write_data - access
//   rf_read_data1/2, rf_done      - register-file response
//   rf_timeout                    - sticky flag, set when an access is aborted
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [ADDR_W-1:0] dec_rs,
    input  logic [ADDR_W-1:0] dec_rt,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              rf_en,
    output logic              rf_reg_write,
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    input  logic              rf_done,
    output logic              rf_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic              rd_pend_q, rd_pend_d;
    logic              wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic [DATA_W-1:0] fwd_a, fwd_b;

    operand_forward #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
        .wr_pend_i (wr_pend_q),
        .wr_reg_i  (wreg_q),
        .wr_data_i (wdata_q),
        .src_reg_i (rs_q),
        .rf_data_i (rf_read_data1),
        .operand_o (fwd_a)
    );

    operand_forward #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
        .wr_pend_i (wr_pend_q),
        .wr_reg_i  (wreg_q),
        .wr_data_i (wdata_q),
        .src_reg_i (rt_q),
        .rf_data_i (rf_read_data2),
        .operand_o (fwd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            wreg_q    <= '0;
            wdata_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            wr_pend_q <= wr_pend_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_pend_d = rd_pend_q;
        wr_pend_d = wr_pend_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                // Both ready in IDLE, so valid alone means the handshake fires;
                // simultaneous requests share one access.
                if (dec_valid || wb_valid) begin
                    rd_pend_d = dec_valid;
                    wr_pend_d = wb_valid;
                    if (dec_valid) begin
                        rs_d = dec_rs;
                        rt_d = dec_rt;
                    end
                    if (wb_valid) begin
                        wreg_d  = wb_reg;
                        wdata_d = wb_data;
                    end
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (rf_done) begin
                    if (rd_pend_q) begin
                        opa_d   = fwd_a;
                        opb_d   = fwd_b;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        tmo_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: if (op_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign dec_ready     = (state_q == ST_IDLE);
    assign wb_ready      = (state_q == ST_IDLE);
    assign op_valid      = (state_q == ST_HOLD);
    assign op_a          = opa_q;
    assign op_b          = opb_q;
    assign rf_en         = (state_q == ST_ISSUE);
    // Write enable is qualified by the strobe so it never lingers outside ISSUE.
    assign rf_reg_write  = (state_q == ST_ISSUE) && wr_pend_q;
    assign rf_read_reg1  = rs_q;
    assign rf_read_reg2  = rt_q;
    assign rf_write_reg  = wreg_q;
    assign rf_write_data = wdata_q;
    assign rf_timeout    = tmo_q;

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Initiator for the register-file access interface. It takes operand-read requests from decode and writeback requests from the writeback stage, merges them into single register-file accesses (one `rf_en` pulse each), and waits for `rf_done`. It applies write-to-read forwarding and presents the operands to execute through a valid/ready handshake. It sits between decode/writeback and the register file in the multicycle MIPS datapath.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register index width
- `TIMEOUT`, 15, WAIT cycles allowed before an access is aborted
- Clock: one clock; reset is asynchronous and active-low. Ports are `clk` and `rst_n`.
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  async active-low reset
- `dec_valid`  in  1  operand-read request
- `dec_ready`  out  1  read request accepted this cycle
- `dec_rs`, `dec_rt`  in  ADDR_W  source register indices
- `wb_valid`  in  1  writeback request
- `wb_ready`  out  1  writeback accepted this cycle
- `wb_reg`  in  ADDR_W  destination index
- `wb_data`  in  DATA_W  writeback data
- `op_valid`  out  1  operands valid
- `op_ready`  in  1  execute consumes operands
- `op_a`, `op_b`  out  DATA_W  operands for rs and rt
- `rf_en`  out  1  access strobe to the register file
- `rf_reg_write`  out  1  write enable for this access
- `rf_read_reg1`, `rf_read_reg2`, `rf_write_reg`  out  ADDR_W  access indices
- `rf_write_data`  out  DATA_W  write data
- `rf_read_data1`, `rf_read_data2`  in  DATA_W  read data, registered by the register file
- `rf_done`  in  1  access complete
- `rf_timeout`  out  1  sticky abort flag

## Operation
- States are IDLE, ISSUE, WAIT and HOLD. Reset enters IDLE.
- **IDLE**
  - `dec_ready` and `wb_ready` are both 1.
  - On the edge where either handshake fires, latch the request (`rd_pend` and/or `wr_pend`, plus indices and data), clear the WAIT counter, and go to ISSUE.
  - If both handshakes fire in the same cycle, they merge into one access.
- **ISSUE**
  - `rf_en` is 1 for exactly this one cycle.
  - `rf_reg_write` equals `wr_pend`.
  - Index and data outputs hold the latched values from ISSUE through WAIT.
  - Next state is WAIT.
- **WAIT**
  - `rf_done` is sampled only in this state. A `rf_done` that stays high from an earlier access is harmless, because the register file updates on the ISSUE edge.
  - On `rf_done`=1:
    - If `rd_pend` is set, capture `op_a`/`op_b` and go to HOLD.
    - Otherwise go to IDLE.
  - If `rf_done` is low, increment the counter. When the counter reaches `TIMEOUT`, set `rf_timeout`, drop the request with no `op_valid`, and go to IDLE.
- **HOLD**
  - `op_valid` is 1 and `op_a`/`op_b` are stable.
  - When `op_ready` is 1, go to IDLE.
- **Forwarding**
  - The register file returns the pre-write value in a merged access.
  - If `wr_pend`, `wb_reg`≠0 and `wb_reg`==rs, then `op_a`=`wb_data`. The same rule applies to rt and `op_b`.
  - Register 0 is never forwarded.
- **Register 0 writes**: a write to register 0 is still issued; the register file ignores it.
- **`rf_timeout`**: cleared only by reset.

## Timing
- Reset values: all outputs are 0, including `op_a`, `op_b`, all `rf_*` outputs and `rf_timeout`. `dec_ready` and `wb_ready` are 1 once IDLE is reached, which is immediate on reset.
- Read latency with a fast responder:
  - Accept edge at cycle 0.
  - `rf_en` high in cycle 1.
  - `rf_done` seen in cycle 2.
  - `op_valid` high from cycle 3.
- Minimum request spacing is 3 cycles for a write-only access and 4 cycles for a read that is consumed immediately.
- `rf_en` and the `rf_*` outputs are decoded from registered state, so they are glitch-free.
- Reset asserted mid-access aborts it immediately. A pending `op_valid` is lost.

## Structure
- Package `regfile_pkg` holds:
  - the state enum
  - the `DATA_W`/`ADDR_W` defaults
  - the default `TIMEOUT`
  - the `REG_ZERO` constant
- Sub-module `operand_forward`: combinational index compare plus mux, instantiated twice (rs and rt).

## Test plan
- **Read only**: regfile preloaded with r5=0x1234 and r6=0xABCD; request rs=5, rt=6. Expect one `rf_en` pulse with `rf_reg_write`=0, then `op_valid` at cycle 3 with `op_a`=0x1234 and `op_b`=0xABCD.
- **Merged forward**: simultaneous dec (rs=7, rt=0) and wb (r7←0xDEAD). Expect a single access with `rf_reg_write`=1, `op_a`=0xDEAD and `op_b`=0. A later read of r7 returns 0xDEAD.
- **Register 0**: wb to r0 with 0xFFFF_FFFF. Expect the access is issued and no `op_valid`. A later read of r0 returns 0, and forwarding is not applied.
- **Backpressure**: hold `op_ready`=0 for 5 cycles. `op_valid` and the operands stay stable, `dec_ready`=0 throughout, and the controller returns to IDLE the cycle after `op_ready`=1.
- **Timeout**: tie `rf_done`=0. After 15 WAIT cycles `rf_timeout`=1, the FSM is in IDLE, `op_valid` never asserts, and the flag persists until reset.
- **Reset mid-WAIT**: pulse `rst_n` low. All outputs go to 0 asynchronously, and the next request completes normally.
